trace_capture: RTL and testbench



---
 rtl/trace_pkg.sv | 47 ++++
 rtl/trace_fifo.sv | 42 ++++
 rtl/trace_capture.sv | 151 +++++++++++++++
 tb/tb_trace_capture.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and entry layout for the commit-trace recorder.
// Entry width grows by TS_W when TRACE_TIMESTAMP_EN is defined.
package trace_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } trace_state_e;

    localparam int unsigned WbAddrW = 5;

    // Field offsets, LSB first: wb_data, wb_addr, wb_en, instr, pc, [ts].
    function automatic int unsigned off_wb_data();
        return 0;
    endfunction

    function automatic int unsigned off_wb_addr(int unsigned xlen);
        return xlen;
    endfunction

    function automatic int unsigned off_wb_en(int unsigned xlen);
        return xlen + WbAddrW;
    endfunction

    function automatic int unsigned off_instr(int unsigned xlen);
        return xlen + WbAddrW + 1;
    endfunction

    function automatic int unsigned off_pc(int unsigned xlen);
        return 2 * xlen + WbAddrW + 1;
    endfunction

    function automatic int unsigned off_ts(int unsigned xlen);
        return 3 * xlen + WbAddrW + 1;
    endfunction

    function automatic int unsigned entry_w(int unsigned xlen, int unsigned ts_w);
`ifdef TRACE_TIMESTAMP_EN
        return 3 * xlen + WbAddrW + 1 + ts_w;
`else
        return 3 * xlen + WbAddrW + 1 + (ts_w * 0);
`endif
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q, rd_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_q[AW-1:0]] <= push_data;
    end

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign level = wr_q - rd_q;
    assign head  = empty ? '0 : mem[rd_q[AW-1:0]];

endmodule

// File: rtl/trace_capture.sv
// Commit-trace recorder: arm/trigger FSM, entry packing, drop accounting, FIFO drain.
// Define TRACE_TIMESTAMP_EN to prepend a free-running cycle timestamp to each entry.
module trace_capture
    import trace_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TS_W    = 32,
    localparam int unsigned ENTRY_W = entry_w(XLEN, TS_W),
    localparam int unsigned LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               commit_valid,
    input  logic [XLEN-1:0]    commit_pc,
    input  logic [XLEN-1:0]    commit_instr,
    input  logic               wb_en,
    input  logic [4:0]         wb_addr,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               arm,
    input  logic               stop,
    input  logic               mode,
    input  logic [XLEN-1:0]    trig_pc,
    input  logic [CNT_W-1:0]   post_count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ENTRY_W-1:0] out_data,
    output logic [1:0]         state_o,
    output logic [LVL_W-1:0]   level,
    output logic [CNT_W-1:0]   drop_cnt
);

    localparam int unsigned OffWbData = off_wb_data();
    localparam int unsigned OffWbAddr = off_wb_addr(XLEN);
    localparam int unsigned OffWbEn   = off_wb_en(XLEN);
    localparam int unsigned OffInstr  = off_instr(XLEN);
    localparam int unsigned OffPc     = off_pc(XLEN);

    trace_state_e     state_q, state_d;
    logic [XLEN-1:0]  trig_pc_q;
    logic [CNT_W-1:0] post_q, rec_cnt_q, drop_q;
    logic [CNT_W-1:0] rec_cnt_inc;
    logic             trig_hit, last_entry;
    logic             arm_take, record;
    logic             push_ok, pop, drop, full, empty;
    logic [ENTRY_W-1:0] entry;

    assign rec_cnt_inc = rec_cnt_q + 1'b1;
    assign trig_hit    = commit_valid && (commit_pc == trig_pc_q);
    assign last_entry  = (post_q != '0) && (rec_cnt_inc == post_q);

    always_ff @(posedge clk) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = StDone;
        end else begin
            unique case (state_q)
                StIdle, StDone: if (arm) state_d = mode ? StArmed : StCapture;
                StArmed:        if (trig_hit) state_d = last_entry ? StDone : StCapture;
                StCapture:      if (commit_valid && last_entry) state_d = StDone;
                default:        ;
            endcase
        end
    end

    // stop suppresses both the arm and any recording in the same cycle.
    always_comb begin
        arm_take = 1'b0;
        record   = 1'b0;
        if (!stop) begin
            unique case (state_q)
                StIdle, StDone: arm_take = arm;
                StArmed:        record   = trig_hit;
                StCapture:      record   = commit_valid;
                default:        ;
            endcase
        end
    end

    // A dropped entry still advances the post-trigger count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            trig_pc_q <= '0;
            post_q    <= '0;
            rec_cnt_q <= '0;
            drop_q    <= '0;
        end else if (arm_take) begin
            trig_pc_q <= trig_pc;
            post_q    <= post_count;
            rec_cnt_q <= '0;
            drop_q    <= '0;
        end else begin
            if (record) rec_cnt_q <= rec_cnt_inc;
            if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    localparam int unsigned OffTs = off_ts(XLEN);
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (!reset) ts_q <= '0;
        else        ts_q <= ts_q + 1'b1;
    end
`endif

    always_comb begin
        entry = '0;
        entry[OffPc +: XLEN]    = commit_pc;
        entry[OffInstr +: XLEN] = commit_instr;
        entry[OffWbEn]          = wb_en;
        if (wb_en) begin
            entry[OffWbAddr +: 5]    = wb_addr;
            entry[OffWbData +: XLEN] = wb_data;
        end
`ifdef TRACE_TIMESTAMP_EN
        entry[OffTs +: TS_W] = ts_q;
`endif
    end

    assign pop     = !empty && out_ready;
    assign push_ok = record && (!full || pop);
    assign drop    = record && !push_ok;

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_ok),
        .push_data (entry),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .head      (out_data)
    );

    assign out_valid = !empty;
    assign state_o   = state_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: directed table, multi-cycle corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_trace_capture;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned TS_W  = 32;
`ifdef TRACE_TIMESTAMP_EN
    localparam int unsigned EW = 3 * XLEN + 6 + TS_W;
`else
    localparam int unsigned EW = 3 * XLEN + 6;
`endif
    localparam int unsigned PC_LSB = 2 * XLEN + 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             commit_valid;
    logic [XLEN-1:0]  commit_pc, commit_instr, wb_data, trig_pc;
    logic             wb_en;
    logic [4:0]       wb_addr;
    logic             arm, stop, mode;
    logic [CNT_W-1:0] post_count;
    logic             out_valid, out_ready;
    logic [EW-1:0]    out_data;
    logic [1:0]       state_o;
    logic [4:0]       level;
    logic [CNT_W-1:0] drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    trace_capture #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .TS_W  (TS_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_instr (commit_instr),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .arm          (arm),
        .stop         (stop),
        .mode         (mode),
        .trig_pc      (trig_pc),
        .post_count   (post_count),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .state_o      (state_o),
        .level        (level),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: state as 0..3, FIFO as a queue of packed entries.
    int              m_state;
    logic [EW-1:0]   m_q[$];
    int              m_drop, m_rec, m_post;
    logic [XLEN-1:0] m_trig;
    logic [31:0]     m_ts;

    function automatic logic [EW-1:0] mk_entry(logic [31:0] ts, logic [31:0] pc,
                                               logic [31:0] ins, logic wen,
                                               logic [4:0] a, logic [31:0] d);
        logic [EW-1:0] e;
        if (!wen) begin
            a = '0;
            d = '0;
        end
`ifdef TRACE_TIMESTAMP_EN
        e = {ts, pc, ins, wen, a, d};
`else
        e = {pc, ins, wen, a, d} | EW'(ts & 32'h0);
`endif
        return e;
    endfunction

    task automatic model_step();
        bit pop, rec;
        int nxt;
        if (!reset) begin
            m_q.delete();
            m_state = 0; m_drop = 0; m_rec = 0; m_post = 0; m_trig = '0; m_ts = '0;
            return;
        end
        pop = (m_q.size() != 0) && out_ready;
        rec = 0;
        nxt = m_state;
        if (stop) nxt = 3;
        else if (m_state == 0 || m_state == 3) begin
            if (arm) begin
                nxt = mode ? 1 : 2;
                m_rec = 0; m_drop = 0; m_trig = trig_pc; m_post = int'(post_count);
            end
        end else if (m_state == 1) rec = commit_valid && (commit_pc == m_trig);
        else rec = commit_valid;
        if (rec) begin
            m_rec++;
            nxt = 2;
            if (m_post != 0 && m_rec == m_post) nxt = 3;
        end
        if (pop) void'(m_q.pop_front());
        if (rec) begin
            if (m_q.size() < DEPTH)
                m_q.push_back(mk_entry(m_ts, commit_pc, commit_instr, wb_en, wb_addr, wb_data));
            else if (m_drop < 65535) m_drop++;
        end
        m_ts++;
        m_state = nxt;
    endtask

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        logic [EW-1:0] exp_head;
        model_step();
        @(posedge clk);
        #1;
        exp_head = (m_q.size() != 0) ? m_q[0] : '0;
        check("model out_valid", out_valid, m_q.size() != 0);
        check("model out_data", out_data, exp_head);
        check("model level", level, m_q.size());
        check("model drop_cnt", drop_cnt, m_drop);
        check("model state", state_o, m_state);
    endtask

    function automatic logic [31:0] head_pc();
        return out_data[PC_LSB +: 32];
    endfunction

    task automatic commit(logic [31:0] pc);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_instr = $urandom;
        wb_en        = 1'($urandom);
        wb_addr      = 5'($urandom);
        wb_data      = $urandom;
        cycle();
        commit_valid = 1'b0;
    endtask

    typedef struct {
        logic        arm;
        logic        cv;
        logic [31:0] pc;
        logic        exp_v;
        logic [4:0]  exp_lvl;
        logic [1:0]  exp_st;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [31:0] ts_a;
        int bias;

        reset = 1'b0; commit_valid = 1'b0; commit_pc = '0; commit_instr = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; arm = 1'b0; stop = 1'b0;
        mode = 1'b0; trig_pc = '0; post_count = '0; out_ready = 1'b0;
        ts_a = '0;

        repeat (2) cycle();
        check("reset state", state_o, 2'd0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_data", out_data, '0);
        check("reset level", level, 5'd0);
        check("reset drop_cnt", drop_cnt, '0);
        reset = 1'b1;

        // Continuous capture, sink always ready: each entry visible one cycle after commit.
        tbl[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 2'd2};
        for (int i = 1; i <= 5; i++)
            tbl[i] = '{1'b0, 1'b1, 32'h0040_0000 + 32'(4 * (i - 1)), 1'b1, 5'd1, 2'd2};
        tbl[6] = '{1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 2'd2};
        mode = 1'b0; post_count = '0; out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            arm = tbl[i].arm;
            commit_valid = tbl[i].cv;
            commit_pc = tbl[i].pc;
            commit_instr = $urandom;
            wb_en = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
            cycle();
            check("tbl out_valid", out_valid, tbl[i].exp_v);
            check("tbl level", level, tbl[i].exp_lvl);
            check("tbl state", state_o, tbl[i].exp_st);
            if (tbl[i].exp_v) check("tbl head pc", head_pc(), tbl[i].pc);
`ifdef TRACE_TIMESTAMP_EN
            if (i == 1) ts_a = out_data[EW-1 -: 32];
            if (i == 2) check("ts step", out_data[EW-1 -: 32] - ts_a, 32'd1);
`endif
        end
        arm = 1'b0; commit_valid = 1'b0;
        check("cont drop_cnt", drop_cnt, '0);

        // Triggered window of three entries starting at the trigger PC.
        stop = 1'b1; cycle(); stop = 1'b0;
        check("stop to done", state_o, 2'd3);
        arm = 1'b1; mode = 1'b1; trig_pc = 32'h0040_0010; post_count = 3; out_ready = 1'b0;
        cycle();
        arm = 1'b0;
        check("armed", state_o, 2'd1);
        for (int i = 0; i < 9; i++) begin
            commit(32'h0040_0000 + 32'(4 * i));
            if (i == 6) check("trig done", state_o, 2'd3);
        end
        check("trig level", level, 5'd3);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("trig head pc", head_pc(), 32'h0040_0010 + 32'(4 * k));
            cycle();
        end
        check("trig drained", out_valid, 1'b0);

        // Overflow, then full with simultaneous push and pop.
        arm = 1'b1; mode = 1'b0; post_count = '0; out_ready = 1'b0;
        cycle();
        arm = 1'b0;
        for (int i = 0; i < 20; i++) commit(32'h0040_1000 + 32'(4 * i));
        check("ovf level", level, 5'd16);
        check("ovf drop", drop_cnt, 16'd4);
        check("ovf head", head_pc(), 32'h0040_1000);
        out_ready = 1'b1;
        commit(32'h0040_2000);
        check("full pushpop level", level, 5'd16);
        check("full pushpop drop", drop_cnt, 16'd4);
        for (int k = 0; k < 16; k++) begin
            check("ovf drain pc", head_pc(),
                  (k < 15) ? 32'h0040_1000 + 32'(4 * (k + 1)) : 32'h0040_2000);
            cycle();
        end
        check("ovf drained", level, 5'd0);
        stop = 1'b1; cycle(); stop = 1'b0;

        // stop beats arm in the same cycle; a later arm clears drop_cnt.
        arm = 1'b1; cycle(); arm = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) commit(32'h0040_3000 + 32'(4 * i));
        check("pre stop drop", drop_cnt, 16'd1);
        stop = 1'b1; arm = 1'b1; cycle(); stop = 1'b0;
        check("stop+arm state", state_o, 2'd3);
        check("stop+arm drop", drop_cnt, 16'd1);
        cycle(); arm = 1'b0;
        check("rearm state", state_o, 2'd2);
        check("rearm drop", drop_cnt, 16'd0);
        out_ready = 1'b1;
        repeat (9) cycle();
        out_ready = 1'b0;
        check("pre reset level", level, 5'd7);
        reset = 1'b0; cycle(); reset = 1'b1;
        check("mid reset valid", out_valid, 1'b0);
        check("mid reset level", level, 5'd0);
        check("mid reset state", state_o, 2'd0);

        // Randomized traffic against the model.
        bias = 2;
        for (int n = 0; n < 4000; n++) begin
            if (n % 200 == 0) bias = $urandom_range(0, 3);
            reset        = ($urandom_range(0, 299) != 0);
            arm          = ($urandom_range(0, 29) == 0);
            stop         = ($urandom_range(0, 59) == 0);
            mode         = 1'($urandom);
            trig_pc      = 32'h0040_0000 + 32'(4 * $urandom_range(0, 7));
            post_count   = CNT_W'($urandom_range(0, 5));
            out_ready    = ($urandom_range(0, 3) < bias);
            commit_valid = ($urandom_range(0, 9) < 6);
            commit_pc    = 32'h0040_0000 + 32'(4 * $urandom_range(0, 7));
            commit_instr = $urandom;
            wb_en        = 1'($urandom);
            wb_addr      = 5'($urandom);
            wb_data      = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
